// File: rtl/timer_pkg.sv
// Shared types and packed-BCD helpers for the Two Mode Timer countdown and stopwatch stages.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_e;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  function automatic logic [BCD_DIGIT_W-1:0] bcd_clamp_digit(input logic [BCD_DIGIT_W-1:0] d);
    return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
  endfunction

  function automatic logic [2*BCD_DIGIT_W-1:0] bcd_clamp(input logic [2*BCD_DIGIT_W-1:0] v);
    return {bcd_clamp_digit(v[7:4]), bcd_clamp_digit(v[3:0])};
  endfunction

  // Saturates at 00 so a stray call can never produce a non-BCD value.
  function automatic logic [2*BCD_DIGIT_W-1:0] bcd_dec(input logic [2*BCD_DIGIT_W-1:0] v);
    logic [BCD_DIGIT_W-1:0] tens;
    logic [BCD_DIGIT_W-1:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (units != '0) begin
      units = units - 4'd1;
    end else if (tens != '0) begin
      units = BCD_MAX_DIGIT;
      tens  = tens - 4'd1;
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles and pulses tick on the wrap from CLK_DIV-1 to 0.
module tick_gen #(
  parameter int unsigned CLK_DIV = 50_000_000,
  parameter int unsigned PRESC_W = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(CLK_DIV - 1);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PRESC_W'(1);
    end
  end

  // With en low the count simply holds, which is how a pause keeps its phase.
  always_comb begin
    tick = en && (cnt_q == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit packed-BCD countdown stage of the Two Mode Timer.
// Optional macro TIMER_AUTORELOAD_EN: reload the last loaded value on expiry and keep running.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50_000_000,
  parameter int unsigned PRESC_W = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start_stop,
  input  logic       clear,
  output logic [7:0] count,
  output logic       running,
  output logic       expired,
  output logic       done
);

  timer_state_e state_q, state_d;
  logic [7:0]   count_q, count_d;
  logic         done_q, done_d;
  logic         running_q, running_d;
  logic         expired_q, expired_d;
  logic         presc_en;
  logic         presc_clr;
  logic         tick;

`ifdef TIMER_AUTORELOAD_EN
  logic [7:0]   reload_q, reload_d;
`endif

  tick_gen #(
    .CLK_DIV (CLK_DIV),
    .PRESC_W (PRESC_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (tick)
  );

  // Priority: clear > load > start_stop > tick. The prescaler only advances
  // when none of the control pulses is present, so a start_stop coinciding
  // with a tick pauses with the prescaler parked at CLK_DIV-1.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    done_d    = 1'b0;
    presc_en  = 1'b0;
    presc_clr = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
    reload_d  = reload_q;
`endif
    if (clear) begin
      count_d   = '0;
      state_d   = IDLE;
      presc_clr = 1'b1;
    end else if (load) begin
      count_d   = bcd_clamp(load_val);
      state_d   = IDLE;
      presc_clr = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
      reload_d  = bcd_clamp(load_val);
`endif
    end else if (start_stop) begin
      unique case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_d   = RUN;
            presc_clr = 1'b1;
          end
        end
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = state_q;
      endcase
    end else if (state_q == RUN) begin
      presc_en = 1'b1;
      if (tick) begin
        if (count_q == 8'h01) begin
          done_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
          if (reload_q != '0) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = DONE;
          end
`else
          count_d = '0;
          state_d = DONE;
`endif
        end else begin
          count_d = bcd_dec(count_q);
        end
      end
    end
    running_d = (state_d == RUN);
    expired_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      reload_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      done_q    <= done_d;
      running_q <= running_d;
      expired_q <= expired_d;
`ifdef TIMER_AUTORELOAD_EN
      reload_q  <= reload_d;
`endif
    end
  end

  always_comb begin
    count   = count_q;
    running = running_q;
    expired = expired_q;
    done    = done_q;
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (CLK_DIV=4): expected output events carry their cycle number.
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [7:0] load_val;
  logic       start_stop;
  logic       clear;
  logic [7:0] count;
  logic       running;
  logic       expired;
  logic       done;

  bcd_countdown_timer #(
    .CLK_DIV (4),
    .PRESC_W (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_val   (load_val),
    .start_stop (start_stop),
    .clear      (clear),
    .count      (count),
    .running    (running),
    .expired    (expired),
    .done       (done)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      tag;
    int         c;
    logic [7:0] cnt;
    logic       run;
    logic       exp;
    logic       dn;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  function automatic void push_ev(input string tag, input int c, input logic [7:0] cnt,
                                  input logic r, input logic x, input logic d);
    ev_t e;
    e.tag = tag; e.c = c; e.cnt = cnt; e.run = r; e.exp = x; e.dn = d;
    sb.push_back(e);
  endfunction

  // Monitor: any change of the output bundle is one DUT event, matched in order.
  initial begin
    logic [10:0] prev;
    logic [10:0] cur;
    bit          first;
    ev_t         e;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        cur = {count, running, expired, done};
        if (first || cur !== prev) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d got count=%h running=%b expired=%b done=%b",
                     cyc, count, running, expired, done);
          end else begin
            e = sb.pop_front();
            if (e.c != cyc || cur !== {e.cnt, e.run, e.exp, e.dn}) begin
              errors++;
              $display("FAIL %s got cyc=%0d count=%h running=%b expired=%b done=%b want cyc=%0d count=%h running=%b expired=%b done=%b",
                       e.tag, cyc, count, running, expired, done, e.c, e.cnt, e.run, e.exp, e.dn);
            end
          end
          first = 1'b0;
        end
        prev = cur;
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(input logic ld, input logic [7:0] v, input logic ss, input logic cl);
    load = ld; load_val = v; start_stop = ss; clear = cl;
    @(negedge clk);
    load = 1'b0; start_stop = 1'b0; clear = 1'b0;
  endtask

  logic [7:0] t2_tbl [11] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                              8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

  initial begin
    int n;
    rst_n = 1'b0; load = 1'b0; load_val = '0; start_stop = 1'b0; clear = 1'b0;
    wait_cyc(3);
    push_ev("reset_state", 4, 8'h00, 0, 0, 0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    wait_cyc(6);

    // Reset asserted mid-run.
    n = cyc;
    push_ev("t1_load37", n + 1, 8'h37, 0, 0, 0);
    push_ev("t1_run", n + 2, 8'h37, 1, 0, 0);
    push_ev("t1_reset", n + 5, 8'h00, 0, 0, 0);
    pulse(1, 8'h37, 0, 0);
    pulse(0, 8'h00, 1, 0);
    wait_cyc(n + 4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset on the very tick edge that would reach 00: no done afterwards.
    n = cyc;
    push_ev("t1b_load01", n + 1, 8'h01, 0, 0, 0);
    push_ev("t1b_run", n + 2, 8'h01, 1, 0, 0);
    push_ev("t1b_reset_on_tick", n + 6, 8'h00, 0, 0, 0);
    pulse(1, 8'h01, 0, 0);
    pulse(0, 8'h00, 1, 0);
    wait_cyc(n + 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(n + 10);

    // Full countdown from 12 including the 10 -> 09 borrow.
    n = cyc;
    push_ev("t2_load12", n + 1, 8'h12, 0, 0, 0);
    push_ev("t2_run", n + 2, 8'h12, 1, 0, 0);
    for (int k = 1; k <= 11; k++) push_ev("t2_dec", n + 2 + 4 * k, t2_tbl[k-1], 1, 0, 0);
`ifdef TIMER_AUTORELOAD_EN
    push_ev("t2_wrap_done", n + 50, 8'h12, 1, 0, 1);
    push_ev("t2_wrap_after", n + 51, 8'h12, 1, 0, 0);
    push_ev("t2_clear", n + 53, 8'h00, 0, 0, 0);
`else
    push_ev("t2_reach00", n + 50, 8'h00, 0, 1, 1);
    push_ev("t2_done_drop", n + 51, 8'h00, 0, 1, 0);
`endif
    pulse(1, 8'h12, 0, 0);
    pulse(0, 8'h00, 1, 0);
    wait_cyc(n + 52);
`ifdef TIMER_AUTORELOAD_EN
    pulse(0, 8'h00, 0, 1);
`endif
    wait_cyc(n + 55);

    // Digit clamping.
    n = cyc;
    push_ev("t3_clamp_A5", n + 1, 8'h95, 0, 0, 0);
    push_ev("t3_clamp_3F", n + 2, 8'h39, 0, 0, 0);
    pulse(1, 8'hA5, 0, 0);
    pulse(1, 8'h3F, 0, 0);
    wait_cyc(n + 4);

    // Pause/resume keeps prescaler phase; start_stop beats a coincident tick.
    n = cyc;
    push_ev("t4_load05", n + 1, 8'h05, 0, 0, 0);
    push_ev("t4_run", n + 2, 8'h05, 1, 0, 0);
    push_ev("t4_dec04", n + 6, 8'h04, 1, 0, 0);
    push_ev("t4_pause", n + 9, 8'h04, 0, 0, 0);
    push_ev("t4_resume", n + 29, 8'h04, 1, 0, 0);
    push_ev("t4_dec03_phase", n + 31, 8'h03, 1, 0, 0);
    push_ev("t4_pause_on_tick", n + 35, 8'h03, 0, 0, 0);
    push_ev("t4_resume2", n + 38, 8'h03, 1, 0, 0);
    push_ev("t4_dec02_held", n + 39, 8'h02, 1, 0, 0);
    push_ev("t4_clear", n + 41, 8'h00, 0, 0, 0);
    pulse(1, 8'h05, 0, 0);
    pulse(0, 8'h00, 1, 0);
    wait_cyc(n + 8);  pulse(0, 8'h00, 1, 0);
    wait_cyc(n + 28); pulse(0, 8'h00, 1, 0);
    wait_cyc(n + 34); pulse(0, 8'h00, 1, 0);
    wait_cyc(n + 37); pulse(0, 8'h00, 1, 0);
    wait_cyc(n + 40); pulse(0, 8'h00, 0, 1);
    wait_cyc(n + 44);

    // start_stop ignored at 00 in IDLE; load beats start_stop; ignored in DONE.
    n = cyc;
    push_ev("t5_load_wins", n + 2, 8'h01, 0, 0, 0);
    push_ev("t5_run", n + 3, 8'h01, 1, 0, 0);
`ifdef TIMER_AUTORELOAD_EN
    push_ev("t5_wrap_done", n + 7, 8'h01, 1, 0, 1);
    push_ev("t5_wrap_after", n + 8, 8'h01, 1, 0, 0);
    push_ev("t5_clear", n + 10, 8'h00, 0, 0, 0);
`else
    push_ev("t5_reach00", n + 7, 8'h00, 0, 1, 1);
    push_ev("t5_done_drop", n + 8, 8'h00, 0, 1, 0);
    push_ev("t5_clear_done", n + 13, 8'h00, 0, 0, 0);
`endif
    pulse(0, 8'h00, 1, 0);
    pulse(1, 8'h01, 1, 0);
    pulse(0, 8'h00, 1, 0);
`ifdef TIMER_AUTORELOAD_EN
    wait_cyc(n + 9);  pulse(0, 8'h00, 0, 1);
`else
    wait_cyc(n + 9);  pulse(0, 8'h00, 1, 0);
    wait_cyc(n + 12); pulse(0, 8'h00, 0, 1);
`endif
    wait_cyc(n + 16);

`ifdef TIMER_AUTORELOAD_EN
    // Auto-reload sequence 03,02,01,03,02,01,03.
    n = cyc;
    push_ev("t6_load03", n + 1, 8'h03, 0, 0, 0);
    push_ev("t6_run", n + 2, 8'h03, 1, 0, 0);
    push_ev("t6_dec02", n + 6, 8'h02, 1, 0, 0);
    push_ev("t6_dec01", n + 10, 8'h01, 1, 0, 0);
    push_ev("t6_wrap1", n + 14, 8'h03, 1, 0, 1);
    push_ev("t6_wrap1_after", n + 15, 8'h03, 1, 0, 0);
    push_ev("t6_dec02b", n + 18, 8'h02, 1, 0, 0);
    push_ev("t6_dec01b", n + 22, 8'h01, 1, 0, 0);
    push_ev("t6_wrap2", n + 26, 8'h03, 1, 0, 1);
    push_ev("t6_wrap2_after", n + 27, 8'h03, 1, 0, 0);
    push_ev("t6_clear", n + 29, 8'h00, 0, 0, 0);
    pulse(1, 8'h03, 0, 0);
    pulse(0, 8'h00, 1, 0);
    wait_cyc(n + 28); pulse(0, 8'h00, 0, 1);
    wait_cyc(n + 32);
`endif

    wait_cyc(cyc + 4);
    while (sb.size() > 0) begin
      ev_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s missing_event got none want cyc=%0d count=%h running=%b expired=%b done=%b",
               e.tag, e.c, e.cnt, e.run, e.exp, e.dn);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Countdown stage of the Two Mode Timer. It holds a two-digit packed-BCD value (00–99), decrements it once per prescaled tick and reports expiry. Its count output drives the 8-bit mux input selected in timer mode (in2). The stopwatch stage drives the other mux input (in1). The count's 8-bit packed-BCD format matches the mux data width exactly.

Parameters:
CLK_DIV, 50_000_000, clk cycles per decrement tick (bench uses 4); must be >= 2
PRESC_W, 26, prescaler counter width; must satisfy 2^PRESC_W >= CLK_DIV

Ports:
clk  input  1  single system clock; all state changes on rising edge
rst_n  input  1  reset, synchronous, active-low
load  input  1  one-cycle pulse: capture load_val
load_val  input  8  packed BCD [7:4]=tens, [3:0]=units
start_stop  input  1  one-cycle pulse: run/pause toggle
clear  input  1  one-cycle pulse: count to 00, go IDLE
count  output  8  current packed-BCD value, to mux in2
running  output  1  high while in RUN
expired  output  1  high while in DONE
done  output  1  single-cycle pulse on reaching 00

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset, sampled at the clk edge with rst_n=0:
  - count=8'h00, state=IDLE, prescaler=0.
  - running=0, expired=0, done=0.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority within one cycle: rst_n > clear > load > start_stop > tick.
- clear: count=00, prescaler=0, go IDLE, from any state.
- load:
  - Each BCD digit > 9 is clamped to 9.
  - count = clamped load_val, prescaler=0, go IDLE, from any state.
  - Loading while in RUN stops the timer.
- start_stop:
  - IDLE with count != 00 -> RUN, prescaler=0.
  - IDLE with count == 00 -> ignored.
  - RUN -> PAUSE; the prescaler holds its value.
  - PAUSE -> RUN; the prescaler resumes from the held value.
  - DONE -> ignored.
- Prescaler: increments only in RUN. At CLK_DIV-1 it wraps to 0 and asserts an internal tick.
- Tick latency: the first decrement occurs CLK_DIV cycles after the edge that entered RUN.
- Decrement on tick:
  - Units digit != 0: units -= 1.
  - Units digit == 0: units = 9 and tens -= 1.
  - count never leaves valid BCD.
- Reaching 00:
  - On the tick edge where count goes 01 -> 00, state -> DONE on that same edge.
  - done is registered and high for exactly the one cycle following that edge.
- DONE: count holds 00. Exit only via load, clear or reset.
- Outputs:
  - running = (state==RUN) and expired = (state==DONE), both decoded from registered state, so no extra latency.
  - count is registered.
- Reset mid-run: everything returns to reset values on that edge. Any pending done is suppressed.
- Simultaneous tick and start_stop in RUN: start_stop wins; pause, no decrement, prescaler holds CLK_DIV-1.

Optional Feature:
Macro TIMER_AUTORELOAD_EN.
- Defined:
  - An internal 8-bit reload register captures the clamped load_val on every load. Reset value is 00.
  - On the 01 -> 00 tick, count takes the reload value and the state stays RUN.
  - done still pulses for one cycle on that edge; expired is never asserted.
  - If the reload value is 00, behaviour is as without the macro.
- Undefined: no reload register; behaviour exactly as above.

Decomposition:
- Package timer_pkg holds:
  - the state enum type (IDLE, RUN, PAUSE, DONE);
  - BCD digit width and BCD_MAX_DIGIT=9;
  - a BCD-decrement function and a digit-clamp function, shared with the stopwatch stage.
- Sub-module tick_gen: prescaler with enable, synchronous clear and hold; output tick.
  - Parameters CLK_DIV and PRESC_W.
  - Instantiated once.

Test Plan (CLK_DIV=4):
1. Reset asserted mid-run with count=8'h37 -> next edge: count=00, running=0, expired=0, done=0.
2. load_val=8'h12, load, start_stop -> count steps 12,11,10,09…01,00 at one step per 4 cycles; 10 -> 09 checks the BCD borrow. done pulses exactly 1 cycle when 00 appears; expired stays high; running=0.
3. load_val=8'hA5 -> count=8'h95 (tens digit clamped). load_val=8'h3F -> count=8'h39.
4. Load 05, start, pause after 6 cycles -> count=04 and holds for 20 cycles. Resume -> next decrement 2 cycles later (prescaler phase retained).
5. start_stop with count=00 in IDLE -> stays IDLE. start_stop in DONE -> ignored. load plus start_stop on the same cycle -> load wins, IDLE.
6. With TIMER_AUTORELOAD_EN: load 03, run -> sequence 03,02,01,03,02… with done pulsing on each wrap; expired is never high.
